// File: rtl/lsu_mem_master.sv
// Load/store requester for a word-addressed Memory with one combinational read port
// and one write port; sub-word stores are done as read-modify-write.
module lsu_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            r_addrLo;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_isStore;
  logic                  r_fault;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_wordIdx;

  logic                  w_accept;
  logic                  w_fault;
  logic [ADDR_WIDTH-1:0] w_wordIdx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_loadExt;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept  = req_valid && req_ready;
  assign w_wordIdx = {2'b00, req_addr[ADDR_WIDTH-1:2]};
  assign w_fault   = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (w_wordIdx >= ADDR_WIDTH'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState      = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !reset;
        if (w_accept) begin
          if (w_fault)                              w_nextState = RESP;
          else if (req_is_store && req_size == 2'b10) w_nextState = WRITE;
          else                                      w_nextState = READ;
        end
      end
      READ: begin
        mem_read_enable = 1'b1;
        w_nextState     = r_isStore ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_enable = !reset;
        w_nextState      = RESP;
      end
      RESP: begin
        resp_valid = !reset;
        if (resp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Little-endian lane pick for loads, and lane replacement for sub-word stores.
  assign w_byte = mem_read_data[{r_addrLo, 3'b000} +: 8];
  assign w_half = mem_read_data[{r_addrLo[1], 4'b0000} +: 16];

  always_comb begin
    w_loadExt = mem_read_data;
    w_merged  = mem_read_data;
    case (r_size)
      2'b00: begin
        w_loadExt = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                               : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
        w_merged[{r_addrLo, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_loadExt = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                               : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        w_merged[{r_addrLo[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addrLo   <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_isStore  <= 1'b0;
      r_fault    <= 1'b0;
      r_tag      <= '0;
      r_rdata    <= '0;
      r_wdata    <= '0;
      r_wordIdx  <= '0;
    end else if (w_accept) begin
      r_addrLo   <= req_addr[1:0];
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_isStore  <= req_is_store;
      r_fault    <= w_fault;
      r_tag      <= req_tag;
      r_rdata    <= '0;
      r_wdata    <= req_wdata;
      r_wordIdx  <= w_wordIdx;
    end else if (r_state == READ) begin
      if (r_isStore) r_wdata <= w_merged;
      else           r_rdata <= w_loadExt;
    end
  end

  assign resp_rdata     = r_rdata;
  assign resp_tag       = r_tag;
  assign resp_fault     = r_fault;
  assign mem_read_addr  = r_wordIdx;
  assign mem_write_addr = r_wordIdx;
  assign mem_write_data = r_wdata;

endmodule
